// File: rtl/wb_mem_slave.sv
// wb_mem_slave
//   Wishbone B4 classic-cycle memory slave. Single-ported, word-addressed RAM
//   with byte-lane write enables, programmable wait states, out-of-range error
//   termination and a post-reset sweep that loads INIT_VAL into every word.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   cyc_i        in   bus cycle valid
//   stb_i        in   request strobe
//   we_i         in   1 = write, 0 = read
//   sel_i        in   byte-lane enables (DATA_W/8)
//   addr_i       in   word address (ADDR_W)
//   wdata_i      in   write data (DATA_W)
//   rdata_o      out  read data, valid while ack_o = 1, held between reads
//   ack_o        out  normal termination, one-cycle pulse
//   err_o        out  error termination (address >= DEPTH), one-cycle pulse
//   init_done_o  out  high once the init sweep has completed
module wb_mem_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 10,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] INIT_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   sel_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  init_done_o
);

  localparam int                NB       = DATA_W / 8;
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [3:0]        WS       = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    sweep_q;
  logic [3:0]          wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [NB-1:0]       sel_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ack_q;
  logic                err_q;
  logic                init_done_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                req;
  logic                commit;
  logic [ADDR_W-1:0]   c_addr;
  logic                c_we;
  logic [NB-1:0]       c_sel;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_oor;
  logic [IDX_W-1:0]    c_idx;

  // The transfer commits on the edge that enters RESP. With no wait states
  // that is the acceptance edge itself, so the live bus values are used;
  // otherwise the values latched at acceptance are used.
  always_comb begin
    req = cyc_i & stb_i;
    if (state_q == S_IDLE) begin
      c_addr  = addr_i;
      c_we    = we_i;
      c_sel   = sel_i;
      c_wdata = wdata_i;
    end else begin
      c_addr  = addr_q;
      c_we    = we_q;
      c_sel   = sel_q;
      c_wdata = wdata_q;
    end
    commit = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE && req && WS == 4'd0) commit = 1'b1;
      if (state_q == S_WAIT && cyc_i && wcnt_q == 4'd1) commit = 1'b1;
    end
    c_oor = {1'b0, c_addr} >= DEPTH_A;
    c_idx = c_addr[IDX_W-1:0];
  end

  // Storage: init sweep or byte-lane write at the commit edge.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_INIT) begin
      mem[sweep_q] <= INIT_VAL;
    end else if (commit && c_we && !c_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (c_sel[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  // Request latches carry data only; they are always written before use.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req) begin
      addr_q  <= addr_i;
      we_q    <= we_i;
      sel_q   <= sel_i;
      wdata_q <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      wcnt_q      <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == LAST_IDX) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req) begin
            wcnt_q  <= WS;
            state_q <= (WS == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // Dropping cyc aborts silently: no write, no termination.
          if (!cyc_i)               state_q <= S_IDLE;
          else if (wcnt_q == 4'd1)  state_q <= S_RESP;
          else                      wcnt_q  <= wcnt_q - 1'b1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
      if (commit) begin
        if (c_oor) begin
          err_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
          if (!c_we) rdata_q <= mem[c_idx];
        end
      end
    end
  end

  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
module tb_wb_mem_slave;

  localparam logic [31:0] IV = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  cyc = '0;
  logic [2:0]  stb = '0;
  logic [2:0]  we  = '0;
  logic [3:0]  sel   [3];
  logic [9:0]  addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [2:0]  idone;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // u0: no wait states, u1: 3 wait states, u2: 2 wait states
  wb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT_STATES(0), .INIT_VAL(IV)) u0 (
    .clk(clk), .rst(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .sel_i(sel[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]),
    .init_done_o(idone[0]));
  wb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT_STATES(3), .INIT_VAL(IV)) u1 (
    .clk(clk), .rst(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .sel_i(sel[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]),
    .init_done_o(idone[1]));
  wb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT_STATES(2), .INIT_VAL(IV)) u2 (
    .clk(clk), .rst(rst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]), .sel_i(sel[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]),
    .init_done_o(idone[2]));

  typedef struct {
    int          k;
    logic        we;
    logic [3:0]  sel;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[16];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transfer. Starts from an idle slave, drives the request
  // until ack/err is observed (bounded), then releases the bus.
  task automatic xfer(input int k, input logic w, input logic [3:0] s, input logic [9:0] a,
                      input logic [31:0] d, output logic o_ack, output logic o_err,
                      output logic [31:0] o_rd, output int lat);
    @(negedge clk);
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdata[k] = d;
    lat = 0; o_ack = 1'b0; o_err = 1'b0; o_rd = '0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[k] || err[k]) break;
    end
    o_ack = ack[k]; o_err = err[k]; o_rd = rdata[k];
    cyc[k] = 1'b0; stb[k] = 1'b0;
    if (!(o_ack || o_err)) begin
      n_vec++; n_bad++;
      $display("FAIL xfer_timeout: unit %0d addr %0d got no termination, required one within 40 cycles", k, a);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a, e;
    logic [31:0] rd;
    logic [7:0]  hist;
    logic        seen;
    int          lat, n, idx;

    for (int k = 0; k < 3; k++) begin
      sel[k] = '0; addr[k] = '0; wdata[k] = '0;
    end

    //           k we  sel    addr     wdata          ack   err   rdata
    vt[0]  = '{0, 1'b0, 4'hF, 10'd0,   32'h0,         1'b1, 1'b0, IV};
    vt[1]  = '{0, 1'b0, 4'hF, 10'd255, 32'h0,         1'b1, 1'b0, IV};
    vt[2]  = '{0, 1'b1, 4'hF, 10'd5,   32'h1122_3344, 1'b1, 1'b0, IV};
    vt[3]  = '{0, 1'b1, 4'h5, 10'd5,   32'hFFFF_FFFF, 1'b1, 1'b0, IV};
    vt[4]  = '{0, 1'b0, 4'h0, 10'd5,   32'h0,         1'b1, 1'b0, 32'h11FF_33FF};
    vt[5]  = '{0, 1'b0, 4'hF, 10'd300, 32'h0,         1'b0, 1'b1, 32'h11FF_33FF};
    vt[6]  = '{0, 1'b1, 4'hF, 10'd300, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h11FF_33FF};
    vt[7]  = '{0, 1'b0, 4'hF, 10'd44,  32'h0,         1'b1, 1'b0, IV};
    vt[8]  = '{0, 1'b1, 4'h0, 10'd6,   32'hCAFE_F00D, 1'b1, 1'b0, IV};
    vt[9]  = '{0, 1'b0, 4'hF, 10'd6,   32'h0,         1'b1, 1'b0, IV};
    vt[10] = '{0, 1'b1, 4'h8, 10'd2,   32'h1234_5678, 1'b1, 1'b0, IV};
    vt[11] = '{0, 1'b0, 4'hF, 10'd2,   32'h0,         1'b1, 1'b0, 32'h12A5_A5A5};
    vt[12] = '{1, 1'b1, 4'hF, 10'd7,   32'h7777_7777, 1'b1, 1'b0, 32'h0};
    vt[13] = '{1, 1'b0, 4'hF, 10'd7,   32'h0,         1'b1, 1'b0, 32'h7777_7777};
    vt[14] = '{1, 1'b0, 4'hF, 10'd1023,32'h0,         1'b0, 1'b1, 32'h7777_7777};
    vt[15] = '{2, 1'b0, 4'hF, 10'd9,   32'h0,         1'b1, 1'b0, IV};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rdata_u%0d", k), rdata[k], 32'h0);
      check($sformatf("rst_flags_u%0d", k), {29'b0, ack[k], err[k], idone[k]}, 32'h0);
    end

    // Init sweep: a read held during INIT must not be terminated.
    @(negedge clk);
    rst = 3'b000;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'd0;
    n = 0; seen = 1'b0;
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (ack[0] || err[0]) seen = 1'b1;
      if (idone[0]) break;
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    check("init_cycles", n, 256);
    check("no_term_during_init", {31'b0, seen}, 32'h0);

    // Table-driven transfers
    for (int i = 0; i < 16; i++) begin
      xfer(vt[i].k, vt[i].we, vt[i].sel, vt[i].addr, vt[i].wdata, a, e, rd, lat);
      check($sformatf("v%0d_ack", i), {31'b0, a}, {31'b0, vt[i].exp_ack});
      check($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vt[i].exp_err});
      check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("v%0d_latency", i), lat, ws_of(vt[i].k) + 1);
    end

    // Wait-state timing on u1: request accepted at edge 0, ack only after edge 3.
    @(negedge clk); @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; addr[1] = 10'd7;
    hist = '0; seen = 1'b0; rd = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      hist[c] = ack[1];
      if (err[1]) seen = 1'b1;
      if (ack[1]) begin
        rd = rdata[1];
        cyc[1] = 1'b0; stb[1] = 1'b0;
      end
    end
    check("ws3_ack_timing", {26'b0, hist[5:0]}, 32'h0000_0008);
    check("ws3_no_err", {31'b0, seen}, 32'h0);
    check("ws3_rdata", rd, 32'h7777_7777);

    // Back-to-back reads on u0 with stb held: ack on alternate cycles.
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 4'hF, 10'(i), 32'hB0B0_0000 | i, a, e, rd, lat);
    @(negedge clk); @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; addr[0] = 10'd0;
    hist = '0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      hist[c] = ack[0];
      if (ack[0]) begin
        check($sformatf("b2b_rdata%0d", idx), rdata[0], 32'hB0B0_0000 | idx);
        idx++;
        if (idx < 4) addr[0] = 10'(idx);
        else begin cyc[0] = 1'b0; stb[0] = 1'b0; end
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    check("b2b_ack_pattern", {24'b0, hist}, 32'h0000_0055);

    // Abort on u2: cyc dropped while in WAIT, write must not land.
    @(negedge clk); @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = 10'd9; wdata[2] = 32'h9999_9999;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack[2] || err[2]) seen = 1'b1;
    end
    check("abort_no_term", {31'b0, seen}, 32'h0);
    xfer(2, 1'b0, 4'hF, 10'd9, 32'h0, a, e, rd, lat);
    check("abort_word_unchanged", rd, IV);

    // Reset during WAIT of a write on u2: no ack, sweep reruns.
    xfer(2, 1'b1, 4'hF, 10'd7, 32'h1111_1111, a, e, rd, lat);
    @(negedge clk); @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = 10'd7; wdata[2] = 32'h2222_2222;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); #1;
    check("midrst_outputs", {28'b0, ack[2], err[2], idone[2], 1'b0}, 32'h0);
    check("midrst_rdata", rdata[2], 32'h0);
    @(negedge clk);
    rst[2] = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (ack[2] || err[2]) seen = 1'b1;
      if (idone[2]) break;
    end
    check("midrst_init_cycles", n, 256);
    check("midrst_no_term", {31'b0, seen}, 32'h0);
    xfer(2, 1'b0, 4'hF, 10'd7, 32'h0, a, e, rd, lat);
    check("midrst_addr7", rd, IV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Parametrised Wishbone B4 classic-cycle memory slave: a single-ported, word-addressed RAM with byte-lane write enables, programmable wait states, out-of-range error signalling and a post-reset initialisation sweep. It replaces the fixed 8-bit/256-entry memory slave on the peripheral bus. It is the standard memory target for bus-level SV verification benches.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 10, word-address width
- DEPTH, 256, implemented words; must be ≤ 2**ADDR_W
- WAIT_STATES, 0, extra cycles inserted before ack/err (0..15)
- INIT_VAL, 0, DATA_W-bit value written to every word by the init sweep
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cyc  in  1  bus cycle valid
- stb  in  1  strobe, request valid
- we  in  1  1 = write, 0 = read
- sel  in  DATA_W/8  byte-lane enables
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, valid while ack=1
- ack  out  1  normal termination, one-cycle pulse
- err  out  1  error termination, one-cycle pulse
- init_done  out  1  high once init sweep complete

## Operation
- States: INIT, IDLE, WAIT, RESP.
- Reset: state→INIT, sweep counter→0, ack=0, err=0, rdata=0, init_done=0.
- INIT: writes INIT_VAL to mem[cnt] each cycle, cnt++. After word DEPTH-1, →IDLE and init_done=1. Requests during INIT are not accepted and not terminated; the master stalls.
- IDLE: on cyc&stb at an edge, latch addr/we/sel/wdata and wait counter=WAIT_STATES. →WAIT if WAIT_STATES>0, else →RESP.
- WAIT: counter decrements each cycle; at 1 →RESP. If cyc=0 is sampled in WAIT (abort), →IDLE with no write and no termination.
- Entering RESP (the registered edge):
  - addr ≥ DEPTH: err=1, no memory change, rdata unchanged.
  - Write: for each lane i with sel[i]=1, mem[addr][8i+7:8i]=wdata lane i. Other lanes are untouched. sel=0 is a legal no-op write and still acks.
  - Read: rdata=mem[addr] (all lanes, sel ignored), ack=1.
- RESP: ack/err high for exactly one cycle, then →IDLE; ack/err return to 0.
- rdata holds its last read value between reads.
- ack and err are never high together.
- Back-to-back: cyc&stb sampled in the cycle after RESP (state IDLE) is a new request. There is no forced bubble beyond the RESP cycle.

## Timing
- Request sampled at edge N (IDLE). ack/err/rdata are high at edge N+1+WAIT_STATES and low at the following edge.
- Minimum throughput: one transfer per 2+WAIT_STATES cycles.
- A write is visible to a read accepted in any later cycle. There is no read-after-write hazard.
- The master holds request signals stable until termination. The slave uses only the values latched at acceptance; changes after acceptance are ignored.
- The init sweep takes exactly DEPTH cycles after rst deasserts. init_done rises in the cycle after the last sweep write.
- rst asserted mid-transfer (WAIT or RESP): no write commits unless the RESP edge has already passed. Outputs return to reset values at the next edge, and the sweep restarts.
- rst is held ≥1 cycle. Memory contents during reset are don't-care until the sweep completes.

## Test plan
- Reset and init: DEPTH=256, INIT_VAL=32'hA5A5_A5A5; release rst → init_done rises after 256 cycles. Read addr 0 and 255 → 32'hA5A5_A5A5 with ack.
- Byte lanes: write 32'h1122_3344 sel=4'hF to addr 5, then write 32'hFFFF_FFFF sel=4'b0101 → read addr 5 returns 32'h11FF_33FF.
- Wait states: WAIT_STATES=3, read sampled at edge N → ack high only at edge N+4, low at N+5. err stays 0 throughout.
- Out of range: read and write addr 300 (ADDR_W=10, DEPTH=256) → err pulse, ack=0, rdata unchanged. A subsequent read of addr 44 (300 mod 256) shows no corruption.
- Back-to-back and abort: with WAIT_STATES=0, hold stb for 4 consecutive reads of addrs 0..3 → ack on alternate cycles with the correct data. With WAIT_STATES=2, drop cyc during WAIT → no ack, target word unchanged.
- Reset mid-operation: assert rst during WAIT of a write to addr 7 → no ack, init sweep reruns, addr 7 reads INIT_VAL.
